// File: rtl/sys_tick_alarm_pkg.sv
// Shared definitions for the system tick alarm block: register map and bit indices.
package sys_tick_alarm_pkg;

  typedef logic [31:0] tick_t;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_COUNT_L = 3'd2;
  localparam logic [2:0] ADDR_COUNT_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L  = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H  = 3'd5;
  localparam logic [2:0] ADDR_ALARM_L = 3'd6;
  localparam logic [2:0] ADDR_ALARM_H = 3'd7;

  localparam int unsigned STAT_ALARM = 0;
  localparam int unsigned STAT_OVF   = 1;
  localparam int unsigned STAT_RUN   = 2;

  localparam int unsigned CTRL_AIE   = 0;
  localparam int unsigned CTRL_OIE   = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

endpackage

// File: rtl/sys_tick_alarm_if.sv
// 16-bit Avalon-MM slave bus as seen by the tick alarm block.
interface sys_tick_alarm_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/sys_tick_edge_det.sv
// Registers the incoming tick level and produces a one-cycle rising-edge pulse.
module sys_tick_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic pulse
);

  // Delayed copy of the input level; tracks even while counting is stopped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= 1'b0;
    else          q <= d;
  end

  assign pulse = d & ~q;

endmodule

// File: rtl/sys_tick_alarm.sv
// System tick counter fed by the interval timer irq: 32-bit count, snapshot,
// alarm compare, overflow detect and a maskable irq on a 16-bit Avalon slave.
module sys_tick_alarm
  import sys_tick_alarm_pkg::*;
#(
  parameter logic  RUN_AT_RESET = 1'b1,
  parameter tick_t ALARM_RESET  = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick_in,
  sys_tick_alarm_if.slave  bus,
  output logic             irq
);

  tick_t       count;
  tick_t       snapshot;
  tick_t       alarm;
  tick_t       count_inc;
  logic [1:0]  control;
  logic        running;
  logic        alarm_flag;
  logic        ovf_flag;
  logic        tick_q;
  logic        tick_evt;
  logic        inc;
  logic        wr_en;
  logic        wr_status, wr_control, wr_count_l, wr_count_h;
  logic        wr_snap, wr_alarm_l, wr_alarm_h;
  logic [15:0] rd_mux;

  sys_tick_edge_det u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (tick_in),
    .q       (tick_q),
    .pulse   (tick_evt)
  );

  assign wr_en      = bus.chipselect & ~bus.write_n;
  assign wr_status  = wr_en & (bus.address == ADDR_STATUS);
  assign wr_control = wr_en & (bus.address == ADDR_CONTROL);
  assign wr_count_l = wr_en & (bus.address == ADDR_COUNT_L);
  assign wr_count_h = wr_en & (bus.address == ADDR_COUNT_H);
  assign wr_snap    = wr_en & ((bus.address == ADDR_SNAP_L) | (bus.address == ADDR_SNAP_H));
  assign wr_alarm_l = wr_en & (bus.address == ADDR_ALARM_L);
  assign wr_alarm_h = wr_en & (bus.address == ADDR_ALARM_H);

  // A count preset discards any tick arriving in the same cycle.
  assign inc       = running & tick_evt & ~(wr_count_l | wr_count_h);
  assign count_inc = count + 32'd1;

  // Tick counter: bus presets take priority over increments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        count <= '0;
    else if (wr_count_l) count[15:0]  <= bus.writedata;
    else if (wr_count_h) count[31:16] <= bus.writedata;
    else if (inc)        count <= count_inc;
  end

  // Snapshot captures the pre-increment count on a write to either half.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     snapshot <= '0;
    else if (wr_snap) snapshot <= count;
  end

  // Alarm compare value, written by halves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alarm <= ALARM_RESET;
    end else begin
      if (wr_alarm_l) alarm[15:0]  <= bus.writedata;
      if (wr_alarm_h) alarm[31:16] <= bus.writedata;
    end
  end

  // Interrupt enables plus run state; START beats STOP in a single write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      control <= '0;
      running <= RUN_AT_RESET;
    end else if (wr_control) begin
      control <= bus.writedata[1:0];
      if (bus.writedata[CTRL_START])     running <= 1'b1;
      else if (bus.writedata[CTRL_STOP]) running <= 1'b0;
    end
  end

  // Sticky flags: a set event in the same cycle as a W1C keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alarm_flag <= 1'b0;
      ovf_flag   <= 1'b0;
    end else begin
      if (inc && (count_inc == alarm))                      alarm_flag <= 1'b1;
      else if (wr_status && bus.writedata[STAT_ALARM])      alarm_flag <= 1'b0;
      if (inc && (count == '1))                             ovf_flag   <= 1'b1;
      else if (wr_status && bus.writedata[STAT_OVF])        ovf_flag   <= 1'b0;
    end
  end

  // Read data selection by word address.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_STATUS:  rd_mux = {13'b0, running, ovf_flag, alarm_flag};
      ADDR_CONTROL: rd_mux = {14'b0, control};
      ADDR_COUNT_L: rd_mux = count[15:0];
      ADDR_COUNT_H: rd_mux = count[31:16];
      ADDR_SNAP_L:  rd_mux = snapshot[15:0];
      ADDR_SNAP_H:  rd_mux = snapshot[31:16];
      ADDR_ALARM_L: rd_mux = alarm[15:0];
      ADDR_ALARM_H: rd_mux = alarm[31:16];
      default:      rd_mux = '0;
    endcase
  end

  // Registered read port: data valid one cycle after the address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.readdata <= '0;
    else          bus.readdata <= rd_mux;
  end

  assign irq = (alarm_flag & control[CTRL_AIE]) | (ovf_flag & control[CTRL_OIE]);

endmodule

// File: tb/tb_sys_tick_alarm.sv
// Directed, table-driven bench for sys_tick_alarm.
module tb_sys_tick_alarm;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tick_in = 1'b0;
  logic irq;

  sys_tick_alarm_if bus ();

  sys_tick_alarm #(
    .RUN_AT_RESET (1'b1),
    .ALARM_RESET  (32'hFFFF_FFFF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tick_in (tick_in),
    .bus     (bus.slave),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef enum int unsigned {K_WR, K_RD, K_TICK, K_HOLD, K_IRQ} kind_e;

  typedef struct {
    kind_e       kind;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad = 0;

  task automatic add(input kind_e k, input logic [2:0] a, input logic [15:0] d,
                     input logic [15:0] e);
    vec_t v;
    v.kind = k; v.addr = a; v.data = d; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [15:0] v);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = a;
    @(negedge clk);
    v = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clk); tick_in = 1'b1;
    @(negedge clk); tick_in = 1'b0;
  endtask

  // Tick edge and bus write land on the same clock edge.
  task automatic tick_with_wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    tick_in = 1'b1;
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
    @(negedge clk);
    tick_in = 1'b0;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [15:0] e);
    logic [15:0] v;
    bus_rd(a, v);
    check(name, v, e);
  endtask

  initial begin
    logic [15:0] v;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;

    // Reset defaults
    add(K_RD,   3'd0, 16'h0000, 16'h0004);
    add(K_RD,   3'd6, 16'h0000, 16'hFFFF);
    add(K_RD,   3'd7, 16'h0000, 16'hFFFF);
    add(K_IRQ,  3'd0, 16'h0000, 16'h0000);
    // Long high level counts once, then three edges
    add(K_HOLD, 3'd0, 16'd10,   16'h0000);
    add(K_RD,   3'd2, 16'h0000, 16'h0001);
    add(K_TICK, 3'd0, 16'h0000, 16'h0000);
    add(K_TICK, 3'd0, 16'h0000, 16'h0000);
    add(K_TICK, 3'd0, 16'h0000, 16'h0000);
    add(K_WR,   3'd4, 16'h0000, 16'h0000);
    add(K_RD,   3'd4, 16'h0000, 16'h0004);
    add(K_RD,   3'd5, 16'h0000, 16'h0000);
    // Alarm at 5 from count 0
    add(K_WR,   3'd2, 16'h0000, 16'h0000);
    add(K_WR,   3'd3, 16'h0000, 16'h0000);
    add(K_WR,   3'd6, 16'h0005, 16'h0000);
    add(K_WR,   3'd7, 16'h0000, 16'h0000);
    add(K_WR,   3'd1, 16'h0001, 16'h0000);
    add(K_TICK, 3'd0, 16'h0000, 16'h0000);
    add(K_TICK, 3'd0, 16'h0000, 16'h0000);
    add(K_TICK, 3'd0, 16'h0000, 16'h0000);
    add(K_TICK, 3'd0, 16'h0000, 16'h0000);
    add(K_IRQ,  3'd0, 16'h0000, 16'h0000);
    add(K_RD,   3'd0, 16'h0000, 16'h0004);
    add(K_TICK, 3'd0, 16'h0000, 16'h0000);
    add(K_IRQ,  3'd0, 16'h0000, 16'h0001);
    add(K_RD,   3'd0, 16'h0000, 16'h0005);
    add(K_WR,   3'd0, 16'h0001, 16'h0000);
    add(K_IRQ,  3'd0, 16'h0000, 16'h0000);
    add(K_RD,   3'd0, 16'h0000, 16'h0004);
    // Wrap to zero
    add(K_WR,   3'd2, 16'hFFFF, 16'h0000);
    add(K_WR,   3'd3, 16'hFFFF, 16'h0000);
    add(K_WR,   3'd1, 16'h0002, 16'h0000);
    add(K_TICK, 3'd0, 16'h0000, 16'h0000);
    add(K_RD,   3'd2, 16'h0000, 16'h0000);
    add(K_RD,   3'd3, 16'h0000, 16'h0000);
    add(K_RD,   3'd0, 16'h0000, 16'h0006);
    add(K_IRQ,  3'd0, 16'h0000, 16'h0001);
    add(K_WR,   3'd0, 16'h0002, 16'h0000);
    add(K_IRQ,  3'd0, 16'h0000, 16'h0000);
    // Stop / start
    add(K_WR,   3'd1, 16'h0008, 16'h0000);
    add(K_TICK, 3'd0, 16'h0000, 16'h0000);
    add(K_TICK, 3'd0, 16'h0000, 16'h0000);
    add(K_TICK, 3'd0, 16'h0000, 16'h0000);
    add(K_RD,   3'd2, 16'h0000, 16'h0000);
    add(K_RD,   3'd0, 16'h0000, 16'h0000);
    add(K_WR,   3'd1, 16'h0004, 16'h0000);
    add(K_TICK, 3'd0, 16'h0000, 16'h0000);
    add(K_RD,   3'd2, 16'h0000, 16'h0001);
    add(K_WR,   3'd1, 16'h000C, 16'h0000);
    add(K_RD,   3'd0, 16'h0000, 16'h0004);
    add(K_TICK, 3'd0, 16'h0000, 16'h0000);
    add(K_RD,   3'd2, 16'h0000, 16'h0002);
    add(K_RD,   3'd6, 16'h0000, 16'h0005);
    add(K_RD,   3'd7, 16'h0000, 16'h0000);
    add(K_WR,   3'd1, 16'h0003, 16'h0000);
    add(K_RD,   3'd1, 16'h0000, 16'h0003);
    add(K_WR,   3'd1, 16'h0000, 16'h0000);
    add(K_RD,   3'd1, 16'h0000, 16'h0000);

    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].kind)
        K_WR:   bus_wr(vecs[i].addr, vecs[i].data);
        K_RD: begin
          bus_rd(vecs[i].addr, v);
          check($sformatf("vec%0d_rd%0d", i, vecs[i].addr), v, vecs[i].exp);
        end
        K_TICK: pulse_tick();
        K_HOLD: begin
          @(negedge clk); tick_in = 1'b1;
          repeat (int'(vecs[i].data)) @(negedge clk);
          tick_in = 1'b0;
          @(negedge clk);
        end
        K_IRQ: begin
          @(negedge clk);
          check($sformatf("vec%0d_irq", i), {15'b0, irq}, vecs[i].exp);
        end
        default: ;
      endcase
    end

    // Count preset coincident with a tick edge: preset wins, no increment
    tick_with_wr(3'd2, 16'h1234);
    rd_check("cnt_wr_vs_tick_l", 3'd2, 16'h1234);
    rd_check("cnt_wr_vs_tick_h", 3'd3, 16'h0000);

    // W1C of alarm_flag in the same cycle as an alarm match
    bus_wr(3'd6, 16'h1236);
    bus_wr(3'd1, 16'h0001);
    pulse_tick();
    tick_with_wr(3'd0, 16'h0001);
    rd_check("w1c_vs_set_status", 3'd0, 16'h0005);
    check("w1c_vs_set_irq", {15'b0, irq}, 16'h0001);

    // Snapshot write coincident with a tick takes the pre-increment count
    bus_wr(3'd0, 16'h0001);
    tick_with_wr(3'd5, 16'h0000);
    rd_check("snap_vs_tick_snap", 3'd4, 16'h1236);
    rd_check("snap_vs_tick_cnt", 3'd2, 16'h1237);
    rd_check("snap_vs_tick_stat", 3'd0, 16'h0004);

    // Alarm rewrite coincident with a matching increment compares the old value
    bus_wr(3'd6, 16'h1238);
    tick_with_wr(3'd6, 16'h9999);
    rd_check("alarm_wr_vs_match_stat", 3'd0, 16'h0005);
    rd_check("alarm_wr_vs_match_alarm", 3'd6, 16'h9999);
    check("pre_reset_irq", {15'b0, irq}, 16'h0001);

    // Asynchronous reset mid-operation
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("async_rst_irq", {15'b0, irq}, 16'h0000);
    check("async_rst_rdata", bus.readdata, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    rd_check("post_rst_status", 3'd0, 16'h0004);
    rd_check("post_rst_control", 3'd1, 16'h0000);
    rd_check("post_rst_count", 3'd2, 16'h0000);
    rd_check("post_rst_snap", 3'd4, 16'h0000);
    rd_check("post_rst_alarm", 3'd6, 16'hFFFF);

    // Presetting count equal to alarm does not raise the alarm flag
    bus_wr(3'd2, 16'hFFFF);
    bus_wr(3'd3, 16'hFFFF);
    rd_check("preset_eq_alarm", 3'd0, 16'h0004);
    pulse_tick();
    rd_check("wrap_after_reset", 3'd0, 16'h0006);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
